// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter onto one single-port on-chip RAM with alternating priority on contention.
// Reads return exactly one cycle after grant; out-of-range accesses are dropped, completed and counted.
module onchip_mem_arbiter #(
  parameter int          DEPTH    = 6050,
  parameter logic [31:0] OOR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [3:0]  m0_byteenable,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [12:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [3:0]  m1_byteenable,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [12:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata,
  output logic [15:0] oor_count
);

  localparam logic [13:0] DEPTH_W = 14'(DEPTH);

  logic        req0, req1;
  logic        grant0, grant1, granted;
  logic        last_grant;
  logic [12:0] sel_address;
  logic        sel_write;
  logic        in_range;
  logic        rd0, rd1;
  logic [1:0]  rd_pend;
  logic        rd_oor;
  logic [15:0] oor_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // last_grant holds the id of the most recently granted master; the other one wins a tie.
  assign grant0  = ~reset & req0 & (~req1 | last_grant);
  assign grant1  = ~reset & req1 & ~grant0;
  assign granted = grant0 | grant1;

  assign m0_waitrequest = reset | (req0 & ~grant0);
  assign m1_waitrequest = reset | (req1 & ~grant1);

  assign sel_address = grant1 ? m1_address : m0_address;
  assign sel_write   = grant1 ? m1_write   : m0_write;
  assign in_range    = {1'b0, sel_address} < DEPTH_W;

  assign mem_address    = sel_address;
  assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = granted;
  assign mem_write      = granted & sel_write & in_range;
  assign mem_clken      = ~reset;

  // A request with both read and write high is a write only.
  assign rd0 = grant0 & m0_read & ~m0_write;
  assign rd1 = grant1 & m1_read & ~m1_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_pend    <= 2'b00;
      rd_oor     <= 1'b0;
      oor_q      <= 16'd0;
    end else begin
      if (granted)
        last_grant <= grant1;
      rd_pend <= {rd1, rd0};
      rd_oor  <= ~in_range;
      if (granted && !in_range && oor_q != 16'hFFFF)
        oor_q <= oor_q + 16'd1;
    end
  end

  assign m0_readdatavalid = rd_pend[0];
  assign m1_readdatavalid = rd_pend[1];
  assign m0_readdata      = rd_pend[0] ? (rd_oor ? OOR_DATA : mem_readdata) : 32'd0;
  assign m1_readdata      = rd_pend[1] ? (rd_oor ? OOR_DATA : mem_readdata) : 32'd0;
  assign oor_count        = oor_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter: directed transfers push expected read data,
// a negedge monitor pops and compares on every readdatavalid.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] m_addr [2];
  logic        m_rd   [2];
  logic        m_wr   [2];
  logic [3:0]  m_be   [2];
  logic [31:0] m_wd   [2];
  logic        m_wait [2];
  logic [31:0] m_rdata[2];
  logic        m_rdv  [2];
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic [15:0] oor_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] mon_exp;

  logic [31:0] ram [8192];
  bit          ram_init_done = 1'b0;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m_addr[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]),
    .m0_byteenable(m_be[0]), .m0_writedata(m_wd[0]),
    .m0_waitrequest(m_wait[0]), .m0_readdata(m_rdata[0]), .m0_readdatavalid(m_rdv[0]),
    .m1_address(m_addr[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]),
    .m1_byteenable(m_be[1]), .m1_writedata(m_wd[1]),
    .m1_waitrequest(m_wait[1]), .m1_readdata(m_rdata[1]), .m1_readdatavalid(m_rdv[1]),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .oor_count(oor_count)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model: data for a sampled address appears the following cycle.
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int k = 0; k < 8192; k++) ram[k] <= 32'd0;
      for (int k = 0; k < 4; k++) begin
        ram[100 + k] <= 32'hA000_0000 + 32'(k);
        ram[200 + k] <= 32'hB000_0000 + 32'(k);
      end
      ram[8191] <= 32'hDEAD_BEEF;
      ram_init_done <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (m_rdv[m]) begin
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL m%0d_unexpected_rdv actual=1 required=0", m);
        end else begin
          if (m == 0) mon_exp = q0.pop_front();
          else        mon_exp = q1.pop_front();
          chk($sformatf("m%0d_readdata", m), m_rdata[m], mon_exp);
        end
      end else begin
        chk($sformatf("m%0d_readdata_idle", m), m_rdata[m], 32'd0);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m0_wait"}, {31'd0, m_wait[0]}, 32'd1);
    chk({tag, "_m1_wait"}, {31'd0, m_wait[1]}, 32'd1);
    chk({tag, "_m0_rdv"}, {31'd0, m_rdv[0]}, 32'd0);
    chk({tag, "_m1_rdv"}, {31'd0, m_rdv[1]}, 32'd0);
    chk({tag, "_m0_rdata"}, m_rdata[0], 32'd0);
    chk({tag, "_m1_rdata"}, m_rdata[1], 32'd0);
    chk({tag, "_cs"}, {31'd0, mem_chipselect}, 32'd0);
    chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_clken"}, {31'd0, mem_clken}, 32'd0);
    chk({tag, "_oor"}, {16'd0, oor_count}, 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the grant edge with the request still driven.
  task automatic issue(input int m, input logic wr, input logic rd, input logic [12:0] a,
                       input logic [3:0] be, input logic [31:0] d, input logic [31:0] exp,
                       input int exp_waits, input int exp_mw);
    int waits;
    waits     = 0;
    m_addr[m] = a;
    m_wr[m]   = wr;
    m_rd[m]   = rd;
    m_be[m]   = be;
    m_wd[m]   = d;
    @(negedge clk);
    while (m_wait[m] && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    chk($sformatf("m%0d_waits_a%0d", m, a), waits, exp_waits);
    if (!m_wait[m]) begin
      if (exp_mw >= 0) chk($sformatf("m%0d_mem_write_a%0d", m, a), {31'd0, mem_write}, exp_mw);
      if (rd && !wr) begin
        if (m == 0) q0.push_back(exp);
        else        q1.push_back(exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int m);
    m_rd[m] = 1'b0;
    m_wr[m] = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    exp_a = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    exp_b = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin
      m_addr[m] = '0; m_rd[m] = 1'b0; m_wr[m] = 1'b0; m_be[m] = '0; m_wd[m] = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Continuous contention straight out of reset: m0 first, then strict alternation.
    fork
      begin
        for (int i = 0; i < 4; i++)
          issue(0, 1'b0, 1'b1, 13'(100 + i), 4'hF, 32'd0, exp_a[i], (i == 0) ? 0 : 1, -1);
        idle(0);
      end
      begin
        for (int j = 0; j < 4; j++)
          issue(1, 1'b0, 1'b1, 13'(200 + j), 4'hF, 32'd0, exp_b[j], 1, -1);
        idle(1);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Write then back-to-back read of the same word.
    issue(0, 1'b1, 1'b0, 13'd5, 4'hF, 32'hA5A5_0001, 32'd0, 0, 1);
    issue(0, 1'b0, 1'b1, 13'd5, 4'hF, 32'd0, 32'hA5A5_0001, 0, 0);
    idle(0);
    @(posedge clk);
    #1;

    // Byte-lane write over a zero word.
    issue(1, 1'b1, 1'b0, 13'd300, 4'hF, 32'h0000_0000, 32'd0, 0, 1);
    issue(1, 1'b1, 1'b0, 13'd300, 4'b0010, 32'hFFFF_FFFF, 32'd0, 0, 1);
    issue(1, 1'b0, 1'b1, 13'd300, 4'hF, 32'd0, 32'h0000_FF00, 0, 0);
    idle(1);
    @(posedge clk);
    #1;

    // Range boundary: last valid word, first invalid word, top of address space.
    issue(0, 1'b1, 1'b0, 13'd6049, 4'hF, 32'h0000_0001, 32'd0, 0, 1);
    idle(0);
    chk("oor_after_6049", {16'd0, oor_count}, 32'd0);
    issue(1, 1'b1, 1'b0, 13'd6050, 4'hF, 32'h1234_5678, 32'd0, 0, 0);
    chk("oor_after_6050", {16'd0, oor_count}, 32'd1);
    issue(1, 1'b0, 1'b1, 13'd8191, 4'hF, 32'd0, 32'h0000_0000, 0, 0);
    idle(1);
    chk("oor_after_8191", {16'd0, oor_count}, 32'd2);
    @(posedge clk);
    #1;

    // Reset between a read grant and its return must cancel the return.
    m_addr[0] = 13'd5;
    m_rd[0]   = 1'b1;
    @(negedge clk);
    chk("rst_cancel_grant", {31'd0, m_wait[0]}, 32'd0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    idle(0);
    @(negedge clk);
    chk_reset_outputs("rst_hold");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("oor_after_reset", {16'd0, oor_count}, 32'd0);

    // Saturation of the out-of-range counter.
    m_addr[0] = 13'd8000;
    m_be[0]   = 4'hF;
    m_wd[0]   = 32'hFFFF_FFFF;
    m_wr[0]   = 1'b1;
    @(negedge clk);
    chk("sat_wait", {31'd0, m_wait[0]}, 32'd0);
    chk("sat_mem_write", {31'd0, mem_write}, 32'd0);
    @(posedge clk);
    repeat (65533) @(posedge clk);
    #1;
    chk("oor_65534", {16'd0, oor_count}, 32'h0000_FFFE);
    @(posedge clk);
    #1;
    chk("oor_65535", {16'd0, oor_count}, 32'h0000_FFFF);
    repeat (5) @(posedge clk);
    #1;
    idle(0);
    chk("oor_65540", {16'd0, oor_count}, 32'h0000_FFFF);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 6050: number of valid 32-bit words in the shared memory.
REQ-002 Parameter OOR_DATA, default 32'h0000_0000: readdata returned for out-of-range reads.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mN_address (N=0,1)  in  13  word address from master N.
REQ-006 mN_read  in  1  read request.
REQ-007 mN_write  in  1  write request.
REQ-008 mN_byteenable  in  4  byte lanes for writes.
REQ-009 mN_writedata  in  32  write data.
REQ-010 mN_waitrequest  out  1  request not accepted this cycle.
REQ-011 mN_readdata  out  32  read data, qualified by readdatavalid.
REQ-012 mN_readdatavalid  out  1  one-cycle read-return strobe.
REQ-013 mem_address  out  13  to memory port address.
REQ-014 mem_byteenable  out  4  to memory byteenable.
REQ-015 mem_chipselect  out  1  to memory chipselect.
REQ-016 mem_write  out  1  to memory write.
REQ-017 mem_writedata  out  32  to memory writedata.
REQ-018 mem_clken  out  1  to memory clken; tied 1 outside reset.
REQ-019 mem_readdata  in  32  from memory; valid the cycle after an address is sampled.
REQ-020 oor_count  out  16  saturating count of out-of-range accesses.

Function
REQ-021 reqN = mN_read | mN_write; a transfer with read and write both high is treated as a write and the read is ignored.
REQ-022 Grant is combinational, one master per cycle: sole requester wins; if both request, the master not granted most recently wins.
REQ-023 Register last_grant updates on every granted cycle; reset value makes m0 win the first contention.
REQ-024 mN_waitrequest = reqN & ~grantN; it is 0 when master N is idle.
REQ-025 A master holds address/data/controls stable while waitrequest is 1; the arbiter does not latch requests.
REQ-026 Memory outputs mux the granted master's address, byteenable and writedata; mem_chipselect = 1 only in a granted cycle.
REQ-027 in_range = address < DEPTH; mem_write = granted write & in_range; out-of-range writes are dropped but still complete (waitrequest 0).
REQ-028 Read latency is exactly 1: for a read granted in cycle T, mN_readdatavalid = 1 in cycle T+1 only, for the requesting master only.
REQ-029 In T+1, mN_readdata = mem_readdata if in_range at T, else OOR_DATA; mN_readdata = 0 whenever readdatavalid is 0.
REQ-030 Pending-read state (one-hot master id plus oor flag) is registered; throughput is one transfer per cycle, back-to-back reads/writes from either master with no bubbles.
REQ-031 A write in T+1 does not disturb a read return for a read granted in T.
REQ-032 oor_count increments by 1 on each granted out-of-range read or write; it holds at 16'hFFFF.
REQ-033 With alternating contention, each master is granted every other cycle; no master waits more than 1 cycle while the other requests continuously.

Reset
REQ-034 While reset = 1: mN_waitrequest = 1, mN_readdatavalid = 0, mN_readdata = 0, mem_chipselect = 0, mem_write = 0, mem_clken = 0, oor_count = 0, pending-read state cleared.
REQ-035 Reset asserted between a read grant and its return cancels the return; no readdatavalid is produced after reset deasserts.
REQ-036 The first cycle after reset deassertion is a normal arbitration cycle.

Verification
REQ-037 m0 write addr 5, data 32'hA5A5_0001, be 4'hF; next m0 read addr 5 -> m0_waitrequest 0 both cycles; m0_readdatavalid one cycle later with 32'hA5A5_0001.
REQ-038 m0 and m1 read continuously from reset -> grants m0,m1,m0,m1...; each readdatavalid toggles every cycle to the correct master.
REQ-039 m1 write addr 6050 data 32'h1234_5678 -> mem_write 0, m1_waitrequest 0, oor_count 1; m1 read addr 8191 -> readdata 0, oor_count 2.
REQ-040 Write be 4'b0010 data 32'hFFFF_FFFF over word 32'h0000_0000, readback -> 32'h0000_FF00.
REQ-041 m0 read granted, reset pulsed next cycle -> no m0_readdatavalid; all outputs at reset values during reset.
REQ-042 Force 65540 out-of-range accesses -> oor_count saturates at 16'hFFFF.
